// File: rtl/seg_pkg.sv
// Shared types for the four-digit multiplexed display scanner.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } seg_state_e;

  // A digit above 0 goes dark when it and every digit to its left carry no nibble and no dp.
  function automatic logic lz_suppress(input logic [15:0] val, input logic [3:0] dpv,
                                       input logic [1:0] idx);
    logic dark;
    dark = (idx != 2'd0);
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && (val[4*i +: 4] != 4'd0 || dpv[i])) dark = 1'b0;
    end
    return dark;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Per-digit slot counter; strobes describe what the coming clock edge does.
module seg_slot_timer #(
  parameter int DIV   = 1000,
  parameter int BLANK = 50,
  localparam int CW   = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          slot_start_o,
  output logic          blank_end_o,
  output logic          slot_end_o
);

  localparam logic [CW-1:0] LAST   = CW'(DIV - 1);
  localparam int            BE_INT = (BLANK > 0) ? BLANK - 1 : 0;
  localparam logic [CW-1:0] BE     = CW'(BE_INT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o        = cnt_q;
  assign slot_start_o = clr_i || cnt_q == LAST;
  assign slot_end_o   = !clr_i && cnt_q == LAST;
  assign blank_end_o  = !clr_i && (BLANK > 0) && cnt_q == BE;

endmodule

// File: rtl/seg_scan4.sv
// Four-digit display scanner: time-multiplexes nibble/dp/digit-enable with an anti-ghost blank.
//  state    | meaning
//  ST_IDLE  | en low, all digits dark, count and index held at 0
//  ST_BLANK | first BLANK cycles of a slot, digit dark
//  ST_ON    | remainder of the slot, digit lit unless suppressed
module seg_scan4 #(
  parameter int DIV   = 1000,
  parameter int BLANK = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        lzb,
  output logic [3:0]  nibble,
  output logic        dp,
  output logic [3:0]  dig_en,
  output logic        frame_done
);
  import seg_pkg::*;

  localparam int            CW       = $clog2(DIV);
  localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 2);
  localparam seg_state_e    ENTRY_ST = (BLANK == 0) ? ST_ON : ST_BLANK;

  // Reset asserts immediately but releases two edges after rst_n rises.
  logic rst_s1_q, rst_s2_q, rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_s1_q <= 1'b0;
      rst_s2_q <= 1'b0;
    end else begin
      rst_s1_q <= 1'b1;
      rst_s2_q <= rst_s1_q;
    end
  end

  assign rst_int_n = rst_s2_q;

  seg_state_e    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [3:0]    act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic          pend_vld_q, pend_vld_d;
  logic [3:0]    nibble_q, nibble_d;
  logic          dp_q, dp_d;
  logic [3:0]    dig_en_q, dig_en_d;
  logic          supp_q, supp_d;
  logic          frame_q, frame_d;
  logic          timer_clr, slot_start, blank_end, slot_end, xfer;
  logic [CW-1:0] cnt;

  assign timer_clr = !en || state_q == ST_IDLE;

  seg_slot_timer #(.DIV(DIV), .BLANK(BLANK)) u_timer (
    .clk          (clk),
    .rst_n        (rst_int_n),
    .clr_i        (timer_clr),
    .cnt_o        (cnt),
    .slot_start_o (slot_start),
    .blank_end_o  (blank_end),
    .slot_end_o   (slot_end)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = 2'd0;
    end else if (state_q == ST_IDLE) begin
      state_d = ENTRY_ST;
      idx_d   = 2'd0;
    end else if (slot_end) begin
      state_d = ENTRY_ST;
      idx_d   = idx_q + 2'd1;
    end else if (blank_end) begin
      state_d = ST_ON;
    end
    frame_d = en && state_q != ST_IDLE && idx_q == 2'd3 && cnt == PRE_LAST;
  end

  // Loads park in pending unless this edge is a frame boundary or the scanner is idle.
  assign xfer = frame_q || state_q == ST_IDLE;

  always_comb begin
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
    end
    if (load && xfer) begin
      act_val_d  = value;
      act_dp_d   = dp_in;
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_vld_d = 1'b1;
    end else if (xfer && pend_vld_q) begin
      act_val_d  = pend_val_q;
      act_dp_d   = pend_dp_q;
      pend_vld_d = 1'b0;
    end
  end

  always_comb begin
    nibble_d = nibble_q;
    dp_d     = dp_q;
    supp_d   = supp_q;
    if (state_d == ST_IDLE) begin
      nibble_d = 4'd0;
      dp_d     = 1'b0;
      supp_d   = 1'b0;
    end else if (slot_start) begin
      nibble_d = act_val_d[{idx_d, 2'b00} +: 4];
      dp_d     = act_dp_d[idx_d];
      supp_d   = lzb && lz_suppress(act_val_d, act_dp_d, idx_d);
    end
    dig_en_d = (state_d == ST_ON && !supp_d) ? (4'b0001 << idx_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      act_val_q  <= 16'd0;
      act_dp_q   <= 4'd0;
      pend_val_q <= 16'd0;
      pend_dp_q  <= 4'd0;
      pend_vld_q <= 1'b0;
      nibble_q   <= 4'd0;
      dp_q       <= 1'b0;
      dig_en_q   <= 4'd0;
      supp_q     <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      nibble_q   <= nibble_d;
      dp_q       <= dp_d;
      dig_en_q   <= dig_en_d;
      supp_q     <= supp_d;
      frame_q    <= frame_d;
    end
  end

  assign nibble     = nibble_q;
  assign dp         = dp_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan4.sv
// Directed bench for seg_scan4 with DIV=8, BLANK=2; frame cycle k maps to slot k/8, count k%8.
module tb_seg_scan4;

  logic        clk = 1'b0;
  logic        rst_n, en, load, lzb;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  nibble, dig_en;
  logic        dp, frame_done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seg_scan4 #(.DIV(8), .BLANK(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .lzb        (lzb),
    .nibble     (nibble),
    .dp         (dp),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  // Expected {nibble, dp, dig_en, frame_done} at frame cycle k; lit marks digits not suppressed.
  function automatic logic [9:0] exp_out(input logic [15:0] v, input logic [3:0] d,
                                         input logic [3:0] lit, input int k);
    int slot;
    int cnt;
    logic [3:0] den;
    logic [3:0] one;
    slot = (k / 8) % 4;
    cnt  = k % 8;
    one  = 4'b0001;
    den  = (cnt >= 2 && lit[slot]) ? (one << slot) : 4'b0000;
    return {v[slot*4 +: 4], d[slot], den, (k % 32) == 31};
  endfunction

  // Stops the scanner for one edge, captures new data, and restarts at frame cycle 0.
  task automatic start_scan(input logic [15:0] v, input logic [3:0] d, input logic l);
    en    = 1'b0;
    load  = 1'b1;
    value = v;
    dp_in = d;
    lzb   = l;
    @(negedge clk);
    load = 1'b0;
    en   = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++;
    if (dig_en !== 4'd0) $display("FAIL reset_dig_en got=%b exp=0000", dig_en);
    else n_pass++;
    n_total++;
    if (nibble !== 4'd0) $display("FAIL reset_nibble got=%h exp=0", nibble);
    else n_pass++;
    n_total++;
    if (dp !== 1'b0) $display("FAIL reset_dp got=%b exp=0", dp);
    else n_pass++;
    n_total++;
    if (frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b exp=0", frame_done);
    else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_scan();
    logic [9:0] obs, expv;
    start_scan(16'h1234, 4'h0, 1'b0);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      obs  = {nibble, dp, dig_en, frame_done};
      expv = exp_out(16'h1234, 4'h0, 4'hF, k);
      n_total++;
      if (obs !== expv) $display("FAIL scan k=%0d got=%h exp=%h", k, obs, expv);
      else n_pass++;
    end
  endtask

  task automatic test_lzb();
    logic [15:0] cv[4];
    logic [3:0]  cd[4];
    logic [3:0]  cl[4];
    logic [9:0]  obs, expv;
    cv = '{16'h0050, 16'h0000, 16'h0000, 16'h0050};
    cd = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
    cl = '{4'b0011, 4'b0001, 4'b0111, 4'b0111};
    for (int c = 0; c < 4; c++) begin
      start_scan(cv[c], cd[c], c != 3);
      for (int k = 0; k < 32; k++) begin
        @(negedge clk);
        obs  = {nibble, dp, dig_en, frame_done};
        expv = exp_out(cv[c], cd[c], cl[c], k);
        n_total++;
        if (obs !== expv) $display("FAIL lzb case=%0d k=%0d got=%h exp=%h", c, k, obs, expv);
        else n_pass++;
        if (c == 3 && k == 20) lzb = 1'b1;
      end
    end
    lzb = 1'b0;
  endtask

  task automatic test_pending();
    logic [15:0] fv[4];
    logic [9:0]  obs, expv;
    fv = '{16'h1234, 16'hABCD, 16'h5678, 16'h9ABC};
    start_scan(16'h1234, 4'h0, 1'b0);
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      obs  = {nibble, dp, dig_en, frame_done};
      expv = exp_out(fv[k / 32], 4'h0, 4'hF, k);
      n_total++;
      if (obs !== expv) $display("FAIL pending k=%0d got=%h exp=%h", k, obs, expv);
      else n_pass++;
      case (k)
        10: begin value = 16'hABCD; load = 1'b1; end
        63: begin value = 16'h5678; load = 1'b1; end
        70: begin value = 16'h1111; load = 1'b1; end
        75: begin value = 16'h9ABC; load = 1'b1; end
        default: load = 1'b0;
      endcase
    end
    load = 1'b0;
  endtask

  task automatic test_en_drop();
    logic [9:0] obs, expv;
    int bad;
    start_scan(16'h1234, 4'h0, 1'b0);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      obs  = {nibble, dp, dig_en, frame_done};
      expv = exp_out(16'h1234, 4'h0, 4'hF, k);
      n_total++;
      if (obs !== expv) $display("FAIL en_drop_pre k=%0d got=%h exp=%h", k, obs, expv);
      else n_pass++;
    end
    en = 1'b0;
    @(negedge clk);
    n_total++;
    if ({dig_en, frame_done} !== 5'd0)
      $display("FAIL en_drop_next got=%b exp=00000", {dig_en, frame_done});
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dig_en !== 4'd0 || frame_done !== 1'b0) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL en_drop_idle got=%0d active_cycles exp=0", bad);
    else n_pass++;
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      obs  = {nibble, dp, dig_en, frame_done};
      expv = exp_out(16'h1234, 4'h0, 4'hF, k);
      n_total++;
      if (obs !== expv) $display("FAIL en_rerise k=%0d got=%h exp=%h", k, obs, expv);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] obs, expv;
    logic [3:0] exp_den;
    start_scan(16'h1234, 4'h0, 1'b0);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      obs  = {nibble, dp, dig_en, frame_done};
      expv = exp_out(16'h1234, 4'h0, 4'hF, k);
      n_total++;
      if (obs !== expv) $display("FAIL rst_pre k=%0d got=%h exp=%h", k, obs, expv);
      else n_pass++;
    end
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    n_total++;
    if (dig_en !== 4'd0) $display("FAIL rst_async_dig_en got=%b exp=0000", dig_en);
    else n_pass++;
    n_total++;
    if ({nibble, dp, frame_done} !== 6'd0)
      $display("FAIL rst_async_other got=%b exp=000000", {nibble, dp, frame_done});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      n_total++;
      if ({nibble, dp, dig_en, frame_done} !== 10'd0)
        $display("FAIL rst_release_idle n=%0d got=%h exp=000", n, {nibble, dp, dig_en, frame_done});
      else n_pass++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      exp_den = (n >= 5) ? 4'b0001 : 4'b0000;
      n_total++;
      if (dig_en !== exp_den) $display("FAIL rst_sync n=%0d got=%b exp=%b", n, dig_en, exp_den);
      else n_pass++;
    end
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    lzb   = 1'b0;
    value = 16'h0000;
    dp_in = 4'h0;
    test_reset();
    test_scan();
    test_lzb();
    test_pending();
    test_en_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
